// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with flush, freeze and write-back operand snoop.
//   clk, rst (async active-low); flush inserts a bubble; freeze holds contents;
//   id_* decoded fields in, ex_* registered copies out; wb_* snoop port refreshes held operands.
module id_ex_stage_reg #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          freeze,
  input  logic          id_valid,
  input  logic          id_wb_en,
  input  logic          id_mem_r_en,
  input  logic          id_mem_w_en,
  input  logic [3:0]    id_exe_cmd,
  input  logic          id_b,
  input  logic          id_s,
  input  logic          id_imm,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_val_rn,
  input  logic [DW-1:0] id_val_rm,
  input  logic [RW-1:0] id_src1,
  input  logic [RW-1:0] id_src2,
  input  logic [RW-1:0] id_dest,
  input  logic [11:0]   id_shift_op,
  input  logic [23:0]   id_simm24,
  input  logic [3:0]    id_status,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  output logic          ex_valid,
  output logic          ex_wb_en,
  output logic          ex_mem_r_en,
  output logic          ex_mem_w_en,
  output logic [3:0]    ex_exe_cmd,
  output logic          ex_b,
  output logic          ex_s,
  output logic          ex_imm,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_val_rn,
  output logic [DW-1:0] ex_val_rm,
  output logic [RW-1:0] ex_src1,
  output logic [RW-1:0] ex_src2,
  output logic [RW-1:0] ex_dest,
  output logic [11:0]   ex_shift_op,
  output logic [23:0]   ex_simm24,
  output logic [3:0]    ex_status
);
  localparam logic [RW-1:0] PC_IDX = RW'(15);
  // R15 is never snooped: the PC value always arrives through the id_pc path.
  logic snoop_rn, snoop_rm;
  always_comb begin
    snoop_rn = wb_en && ex_valid && wb_dest == ex_src1 && ex_src1 != PC_IDX;
    snoop_rm = wb_en && ex_valid && wb_dest == ex_src2 && ex_src2 != PC_IDX;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      ex_valid    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_mem_r_en <= 1'b0;
      ex_mem_w_en <= 1'b0;
      ex_exe_cmd  <= '0;
      ex_b        <= 1'b0;
      ex_s        <= 1'b0;
      ex_imm      <= 1'b0;
      ex_pc       <= '0;
      ex_val_rn   <= '0;
      ex_val_rm   <= '0;
      ex_src1     <= '0;
      ex_src2     <= '0;
      ex_dest     <= '0;
      ex_shift_op <= '0;
      ex_simm24   <= '0;
      ex_status   <= '0;
    end else if (freeze) begin
      if (snoop_rn) ex_val_rn <= wb_value;
      if (snoop_rm) ex_val_rm <= wb_value;
    end else begin
      // A bubble from ID carries data but must never cause side effects.
      ex_valid    <= id_valid;
      ex_wb_en    <= id_valid && id_wb_en;
      ex_mem_r_en <= id_valid && id_mem_r_en;
      ex_mem_w_en <= id_valid && id_mem_w_en;
      ex_exe_cmd  <= id_exe_cmd;
      ex_b        <= id_valid && id_b;
      ex_s        <= id_valid && id_s;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
      ex_val_rn   <= id_val_rn;
      ex_val_rm   <= id_val_rm;
      ex_src1     <= id_src1;
      ex_src2     <= id_src2;
      ex_dest     <= id_dest;
      ex_shift_op <= id_shift_op;
      ex_simm24   <= id_simm24;
      ex_status   <= id_status;
    end
  end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed and random checks of the ID/EX register against a field-level model.
module tb_id_ex_stage_reg;
  typedef struct packed {
    logic        valid, wb_en, mem_r_en, mem_w_en;
    logic [3:0]  cmd;
    logic        b, s, imm;
    logic [31:0] pc, rn, rm;
    logic [3:0]  src1, src2, dest;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  status;
  } st_t;

  logic clk = 0, rst = 0, flush = 0, freeze = 0, wb_en = 0;
  logic [3:0] wb_dest = 0;
  logic [31:0] wb_value = 0;
  st_t id = '0, m = '0, obs;
  int total = 0, passed = 0;

  logic ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
  logic [3:0] ex_exe_cmd, ex_src1, ex_src2, ex_dest, ex_status;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_simm24;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .id_valid(id.valid), .id_wb_en(id.wb_en), .id_mem_r_en(id.mem_r_en), .id_mem_w_en(id.mem_w_en),
    .id_exe_cmd(id.cmd), .id_b(id.b), .id_s(id.s), .id_imm(id.imm),
    .id_pc(id.pc), .id_val_rn(id.rn), .id_val_rm(id.rm),
    .id_src1(id.src1), .id_src2(id.src2), .id_dest(id.dest),
    .id_shift_op(id.shop), .id_simm24(id.simm), .id_status(id.status),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_exe_cmd(ex_exe_cmd), .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
    .ex_shift_op(ex_shift_op), .ex_simm24(ex_simm24), .ex_status(ex_status)
  );

  assign obs = {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_exe_cmd, ex_b, ex_s, ex_imm,
                ex_pc, ex_val_rn, ex_val_rm, ex_src1, ex_src2, ex_dest, ex_shift_op, ex_simm24, ex_status};

  task automatic chk(input string tag, input st_t exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_v(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic rand_id();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    id = r[158:0];
  endtask

  // Reference behaviour of one clock edge, written from the register's rules.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst || flush) m = '0;
    else if (freeze) begin
      if (wb_en && m.valid && m.src1 != 15 && wb_dest == m.src1) m.rn = wb_value;
      if (wb_en && m.valid && m.src2 != 15 && wb_dest == m.src2) m.rm = wb_value;
    end else begin
      m = id;
      if (!id.valid) {m.wb_en, m.mem_r_en, m.mem_w_en, m.b, m.s} = '0;
    end
    #1 chk(tag, m);
  endtask

  initial begin
    #1 chk("reset_initial", '0);
    @(negedge clk) rst = 1;
    // Basic load
    rand_id(); id.valid = 1; id.cmd = 4'b0010; id.rn = 32'h5; id.dest = 3;
    step("load");
    chk_v("load_cmd", 32'(ex_exe_cmd), 2);
    chk_v("load_rn", ex_val_rn, 5);
    chk_v("load_dest", 32'(ex_dest), 3);
    chk_v("load_valid", 32'(ex_valid), 1);
    // Async reset mid-cycle with a valid entry held
    #2 rst = 0;
    #1 m = '0; chk("reset_async", m);
    rand_id(); id.valid = 1;
    step("reset_hold1");
    step("reset_hold2");
    @(negedge clk) rst = 1;
    // Flush beats freeze
    rand_id(); id.valid = 1; id.wb_en = 1;
    step("pre_flush");
    flush = 1; freeze = 1; rand_id();
    step("flush_freeze");
    chk_v("flush_valid", 32'(ex_valid), 0);
    chk_v("flush_wb_en", 32'(ex_wb_en), 0);
    chk_v("flush_rn", ex_val_rn, 0);
    flush = 0; freeze = 0;
    // Snoop both operands from the same register
    rand_id(); id.valid = 1; id.src1 = 4; id.src2 = 4;
    step("pre_snoop");
    freeze = 1; wb_en = 1; wb_dest = 4; wb_value = 32'hDEAD_BEEF; rand_id();
    step("snoop");
    chk_v("snoop_rn", ex_val_rn, 32'hDEAD_BEEF);
    chk_v("snoop_rm", ex_val_rm, 32'hDEAD_BEEF);
    // R15 is not snooped
    freeze = 0; wb_en = 0;
    rand_id(); id.valid = 1; id.src1 = 15; id.src2 = 15;
    step("pre_r15");
    freeze = 1; wb_en = 1; wb_dest = 15; wb_value = 32'h1234_5678; rand_id();
    step("r15_no_snoop");
    // Bubble load then a three-cycle freeze with no write-back
    freeze = 0; wb_en = 0;
    rand_id(); id.valid = 0; id.wb_en = 1; id.mem_w_en = 1;
    step("bubble");
    chk_v("bubble_wb_en", 32'(ex_wb_en), 0);
    chk_v("bubble_mem_w_en", 32'(ex_mem_w_en), 0);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); wb_dest = 4'($urandom); wb_value = $urandom;
      step("bubble_freeze");
    end
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 9) < 4);
      wb_en = $urandom_range(0, 1) == 1;
      wb_dest = ($urandom_range(0, 1) == 1) ? m.src1 : 4'($urandom);
      wb_value = $urandom;
      step("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
